// File: rtl/cfg_issuer_pkg.sv
// Shared types for the configuration issuer: default field widths,
// issue FSM states and the packed descriptor layout.
package cfg_issuer_pkg;

  localparam int unsigned WICP_CWIDTH_DEF = 32;
  localparam int unsigned TMPC_CWIDTH_DEF = 32;
  localparam int unsigned POST_CWIDTH_DEF = 16;
  localparam int unsigned DATA_CWIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } issuer_state_t;

  typedef struct packed {
    logic [WICP_CWIDTH_DEF-1:0] wicp;
    logic [TMPC_CWIDTH_DEF-1:0] tmpc;
    logic [POST_CWIDTH_DEF-1:0] post;
    logic [DATA_CWIDTH_DEF-1:0] data;
  } cfg_desc_t;

endpackage

// File: rtl/cfg_desc_fifo.sv
// Synchronous descriptor FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module cfg_desc_fifo
  import cfg_issuer_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter type         desc_t = cfg_desc_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  desc_t                  wdata,
  output desc_t                  rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  desc_t        mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/cfg_issuer.sv
// Buffers configuration descriptors and issues them one at a time on cfg_*,
// tracking cfg_busy to completion. Define CFG_ISSUER_WATCHDOG_EN for the ack/done timeout.
module cfg_issuer
  import cfg_issuer_pkg::*;
#(
  parameter int unsigned WICP_CWIDTH = WICP_CWIDTH_DEF,
  parameter int unsigned TMPC_CWIDTH = TMPC_CWIDTH_DEF,
  parameter int unsigned POST_CWIDTH = POST_CWIDTH_DEF,
  parameter int unsigned DATA_CWIDTH = DATA_CWIDTH_DEF,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TO_CYCLES   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [WICP_CWIDTH-1:0] desc_wicp,
  input  logic [TMPC_CWIDTH-1:0] desc_tmpc,
  input  logic [POST_CWIDTH-1:0] desc_post,
  input  logic [DATA_CWIDTH-1:0] desc_data,
  output logic                   cfg_valid,
  output logic [WICP_CWIDTH-1:0] cfg_wicp_data,
  output logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
  output logic [POST_CWIDTH-1:0] cfg_post_data,
  output logic [DATA_CWIDTH-1:0] cfg_data_data,
  input  logic                   cfg_busy,
  output logic                   issue_done,
  output logic [15:0]            issue_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   cfg_err
);

  typedef struct packed {
    logic [WICP_CWIDTH-1:0] wicp;
    logic [TMPC_CWIDTH-1:0] tmpc;
    logic [POST_CWIDTH-1:0] post;
    logic [DATA_CWIDTH-1:0] data;
  } issue_desc_t;

  issuer_state_t state_q, state_d;
  issue_desc_t   data_q, data_d;
  issue_desc_t   fifo_wdata;
  issue_desc_t   fifo_head;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          wd_abort;

  assign fifo_wdata = '{wicp: desc_wicp, tmpc: desc_tmpc, post: desc_post, data: desc_data};

  cfg_desc_fifo #(
    .DEPTH  (DEPTH),
    .desc_t (issue_desc_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (desc_valid),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef CFG_ISSUER_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TO_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           wd_expired;

  assign wd_expired = (wd_q == WDW'(TO_CYCLES - 1));
  assign wd_abort   = wd_expired &&
                      (((state_q == WAIT_ACK) && !cfg_busy) ||
                       ((state_q == WAIT_DONE) && cfg_busy));

  // Restarts on entry to each wait state, so ACK and DONE each get the full budget.
  always_comb begin
    wd_d  = '0;
    err_d = err_q | wd_abort;
    if (state_q == WAIT_ACK) begin
      wd_d = cfg_busy ? '0 : wd_q + WDW'(1);
    end else if (state_q == WAIT_DONE) begin
      wd_d = wd_q + WDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign cfg_err = err_q;
`else
  assign wd_abort = 1'b0;
  assign cfg_err  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      // The completion cycle is spent idle, giving the 4-cycle issue spacing.
      IDLE: begin
        if (!fifo_empty && !cfg_busy && !done_q) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          valid_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = cfg_busy ? WAIT_DONE : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (cfg_busy) begin
          state_d = WAIT_DONE;
        end else if (wd_abort) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!cfg_busy) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end else if (wd_abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign desc_ready    = !fifo_full;
  assign cfg_valid     = valid_q;
  assign cfg_wicp_data = data_q.wicp;
  assign cfg_tmpc_data = data_q.tmpc;
  assign cfg_post_data = data_q.post;
  assign cfg_data_data = data_q.data;
  assign issue_done    = done_q;
  assign issue_cnt     = cnt_q;

endmodule

// File: doc/cfg_issuer.md
# cfg_issuer

Configuration transmitter for the PE-array accelerator. It buffers configuration descriptors from a host/sequencer port and issues them one at a time over the accelerator's `cfg_*` interface. For each descriptor it drives `cfg_valid` and the four data fields, then tracks `cfg_busy` until the accelerator has consumed the descriptor. It is the sending end of the interface the accelerator receives on.

## Interface
Parameters:
- `WICP_CWIDTH`, 32: width of the WICP config field.
- `TMPC_CWIDTH`, 32: width of the TMPC config field.
- `POST_CWIDTH`, 16: width of the POST config field.
- `DATA_CWIDTH`, 32: width of the DATA config field.
- `DEPTH`, 8: descriptor FIFO depth; must be a power of two, ≥2.
- `TO_CYCLES`, 64: watchdog limit; used only when the watchdog is compiled in.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `desc_valid`, in, 1: host offers a descriptor.
- `desc_ready`, out, 1: FIFO not full. A push occurs when `desc_valid & desc_ready`.
- `desc_wicp`, `desc_tmpc`, `desc_post`, `desc_data`, in, field widths: descriptor fields.
- `cfg_valid`, out, 1: one-cycle issue strobe.
- `cfg_wicp_data`, `cfg_tmpc_data`, `cfg_post_data`, `cfg_data_data`, out, field widths: fields of the issued descriptor.
- `cfg_busy`, in, 1: accelerator is processing a descriptor.
- `issue_done`, out, 1: one-cycle pulse when a descriptor completes.
- `issue_cnt`, out, 16: count of completed descriptors; wraps modulo 2^16.
- `fifo_level`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `cfg_err`, out, 1: sticky watchdog error flag.

## Operation
- **Reset values:** every output is 0, except `desc_ready`, which is 1. FSM is in IDLE and the FIFO is empty.
- **FSM states and transitions:**
  - IDLE → ISSUE when the FIFO is non-empty and `cfg_busy`=0. The head descriptor is popped into the output registers.
  - ISSUE: `cfg_valid`=1 for exactly this cycle. Then → WAIT_ACK.
  - WAIT_ACK: wait for `cfg_busy`=1, then → WAIT_DONE.
    - If `cfg_busy` is already 1 in the ISSUE cycle, go directly ISSUE → WAIT_DONE.
  - WAIT_DONE: wait for `cfg_busy`=0. Then pulse `issue_done`, increment `issue_cnt`, and → IDLE.
- **Data stability:** `cfg_*_data` hold their value from ISSUE until the next pop. They never change while `cfg_busy`=1.
- **FIFO boundaries:**
  - A push into a full FIFO is not accepted; the host holds the descriptor.
  - Simultaneous push and pop while full is allowed only because `desc_ready` was already 0. The push is refused and the level drops by one.
  - Simultaneous push and pop at any other level leaves the level unchanged.
- **`cfg_busy` in IDLE:** if `cfg_busy`=1 while in IDLE (the accelerator is occupied by another master), no issue takes place.
- **Reset mid-transaction:** the FSM returns to IDLE, the FIFO is flushed, and `cfg_valid` drops asynchronously. The accelerator is not notified.

## Timing
- **Push-to-issue latency:** a push accepted at edge k into an empty FIFO, with the FSM idle and `cfg_busy`=0, gives `cfg_valid` high during cycle k+1 → k+2.
- **Completion:** `issue_done` is registered. It is high in the cycle after the edge at which `cfg_busy` is sampled 0 in WAIT_DONE.
- **Back-to-back issues:** minimum spacing between successive `cfg_valid` pulses is 4 cycles (ISSUE, WAIT_DONE with 1-cycle busy, done cycle, IDLE→ISSUE).
- **Register timing:** `desc_ready` and `fifo_level` are registered and reflect the state after the current edge.

## Configuration
- **`CFG_ISSUER_WATCHDOG_EN` defined:**
  - A counter runs in WAIT_ACK and in WAIT_DONE.
  - Reaching `TO_CYCLES` in either state sets `cfg_err` (sticky until `rst`) and forces the FSM to IDLE, abandoning the descriptor. No `issue_done` pulse and no count increment occur.
- **Macro undefined:** no counter logic is present, `cfg_err` is tied to 0, and WAIT states wait indefinitely.

## Structure
- **Package `cfg_issuer_pkg`:**
  - Default field-width constants.
  - FSM state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE).
  - Packed struct `cfg_desc_t` holding the four fields.
- **Sub-module `cfg_desc_fifo`:** synchronous FIFO of `cfg_desc_t`, DEPTH entries, with level output. Pointers are one bit wider than needed for full/empty detection.

## Test plan
- **Single descriptor:** push {wicp=0x11, tmpc=0x22, post=0x33, data=0x44}; bench raises `cfg_busy` for 3 cycles after `cfg_valid` → one `cfg_valid` pulse with those values; `issue_done` fires once; `issue_cnt`=1.
- **Fill to full:** push 9 descriptors with busy held high → `desc_ready`=0 after the 8th push; `fifo_level`=8; the 9th is accepted only after the first pop; order is preserved.
- **Busy in IDLE:** hold `cfg_busy`=1 while the FIFO is non-empty → no `cfg_valid`; issue occurs 1 cycle after busy drops.
- **Fast accelerator:** busy asserted in the same cycle as `cfg_valid` → direct ISSUE→WAIT_DONE; 16 descriptors complete; `issue_cnt`=16.
- **Reset mid-transaction:** assert `rst` in WAIT_DONE → all outputs return to reset values immediately; `fifo_level`=0.
- **Watchdog (with `CFG_ISSUER_WATCHDOG_EN`, `TO_CYCLES`=10):** never raise busy → `cfg_err`=1 after 10 cycles in WAIT_ACK; FSM in IDLE; next descriptor issues normally.
